// File: rtl/split_2_sampler_ctrl.sv
// LFSR-driven candidate sequencer for the split_2 checker.
// Collects satisfying assignments and streams them over valid/ready.
module split_2_sampler_ctrl #(
    parameter int TRY_W = 16,
    parameter int SOL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [38:0]      seed,
    input  logic [TRY_W-1:0] max_tries,
    input  logic [SOL_W-1:0] num_solutions,
    output logic [14:0]      var_7,
    output logic [14:0]      var_17,
    output logic [8:0]       var_24,
    input  logic             chk_x,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic [14:0]      sol_var_7,
    output logic [14:0]      sol_var_17,
    output logic [8:0]       sol_var_24,
    output logic             busy,
    output logic             done,
    output logic             found_all,
    output logic [TRY_W-1:0] tries_used
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        EMIT,
        DONE
    } state_t;

    state_t           state;
    logic [38:0]      lfsr;
    logic [38:0]      lfsr_step;
    logic [TRY_W-1:0] max_q;
    logic [SOL_W-1:0] nsol_q;
    logic [SOL_W-1:0] sol_cnt;
    logic [TRY_W-1:0] tries_sat;
    logic [SOL_W-1:0] cnt_sat;
    logic [TRY_W:0]   tries_inc;
    logic             tries_last;

    assign lfsr_step  = {lfsr[37:0], lfsr[38] ^ lfsr[34]};
    assign tries_inc  = {1'b0, tries_used} + 1'b1;
    assign tries_last = (tries_inc == {1'b0, max_q});
    assign tries_sat  = (&tries_used) ? tries_used : tries_inc[TRY_W-1:0];
    assign cnt_sat    = (&sol_cnt) ? sol_cnt : sol_cnt + 1'b1;

    assign busy = (state != IDLE);

    // Candidates are gated to zero while idle so reset leaves all outputs low.
    assign var_7  = busy ? lfsr[14:0]  : '0;
    assign var_17 = busy ? lfsr[29:15] : '0;
    assign var_24 = busy ? lfsr[38:30] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= 39'h1;
            max_q      <= '0;
            nsol_q     <= '0;
            sol_cnt    <= '0;
            tries_used <= '0;
            sol_valid  <= 1'b0;
            sol_var_7  <= '0;
            sol_var_17 <= '0;
            sol_var_24 <= '0;
            done       <= 1'b0;
            found_all  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        max_q      <= max_tries;
                        nsol_q     <= num_solutions;
                        tries_used <= '0;
                        sol_cnt    <= '0;
                        found_all  <= 1'b0;
                        lfsr       <= (seed == '0) ? 39'h1 : seed;
                        if (num_solutions == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            found_all <= 1'b1;
                        end else if (max_tries == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    tries_used <= tries_sat;
                    if (chk_x) begin
                        sol_var_7  <= lfsr[14:0];
                        sol_var_17 <= lfsr[29:15];
                        sol_var_24 <= lfsr[38:30];
                        sol_valid  <= 1'b1;
                        state      <= EMIT;
                    end else if (tries_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        lfsr <= lfsr_step;
                    end
                end
                EMIT: begin
                    if (sol_ready) begin
                        sol_valid <= 1'b0;
                        sol_cnt   <= cnt_sat;
                        if (cnt_sat == nsol_q) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            found_all <= 1'b1;
                        end else if (tries_used == max_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            lfsr  <= lfsr_step;
                            state <= SEARCH;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
